// File: rtl/store_buffer_if.sv
// Handshake and memory-port bundle for the store buffer.
// Core side drives stores and loads; buffer side drives status and memory writes.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [2:0]        st_func3;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              st_ready;

    logic              ld_valid;
    logic [2:0]        ld_func3;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_stall;

    logic              mem_write;
    logic [2:0]        mem_func3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    logic              sb_empty;
    logic [CW-1:0]     sb_count;

    modport master (
        output st_valid, st_func3, st_addr, st_data,
        output ld_valid, ld_func3, ld_addr,
        input  st_ready, ld_stall,
        input  mem_write, mem_func3, mem_addr, mem_data,
        input  sb_empty, sb_count
    );

    modport slave (
        input  st_valid, st_func3, st_addr, st_data,
        input  ld_valid, ld_func3, ld_addr,
        output st_ready, ld_stall,
        output mem_write, mem_func3, mem_addr, mem_data,
        output sb_empty, sb_count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the store path and data memory with load-overlap stall.
// Define STORE_BYPASS_EN to write stores straight through when the buffer is empty.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [2:0]        e_func3 [DEPTH];
    logic [ADDR_W-1:0] e_addr  [DEPTH];
    logic [31:0]       e_data  [DEPTH];
    logic [DEPTH-1:0]  e_valid;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;

    logic st_legal, port_free, drain, push, bypass, stall;
    logic [ADDR_W-1:0] ld_sz;

    function automatic logic [ADDR_W-1:0] st_size(input logic [2:0] f);
        case (f)
            3'b000:  st_size = ADDR_W'(1);
            3'b001:  st_size = ADDR_W'(2);
            default: st_size = ADDR_W'(4);
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] ld_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: ld_size = ADDR_W'(1);
            3'b001, 3'b101: ld_size = ADDR_W'(2);
            default:        ld_size = ADDR_W'(4);
        endcase
    endfunction

    assign st_legal = (bus.st_func3 == 3'b000) ||
                      (bus.st_func3 == 3'b001) ||
                      (bus.st_func3 == 3'b010);

    assign ld_sz = ld_size(bus.ld_func3);

    // Spans overlap iff either start lies inside the other span (mod 2^ADDR_W).
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && bus.ld_valid) begin
                if (((e_addr[i] - bus.ld_addr) < ld_sz) ||
                    ((bus.ld_addr - e_addr[i]) < st_size(e_func3[i])))
                    stall = 1'b1;
            end
        end
    end

    assign port_free = !bus.ld_valid || stall;
    assign drain     = (cnt != '0) && port_free;
    assign bus.st_ready = (cnt < FULL);

`ifdef STORE_BYPASS_EN
    assign bypass = (cnt == '0) && port_free && bus.st_valid && st_legal;
`else
    assign bypass = 1'b0;
`endif

    assign push = bus.st_valid && bus.st_ready && st_legal && !bypass;

    always_comb begin
        bus.mem_write = 1'b0;
        bus.mem_func3 = '0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        if (drain) begin
            bus.mem_write = 1'b1;
            bus.mem_func3 = e_func3[head];
            bus.mem_addr  = e_addr[head];
            bus.mem_data  = e_data[head];
        end else if (bypass) begin
            bus.mem_write = 1'b1;
            bus.mem_func3 = bus.st_func3;
            bus.mem_addr  = bus.st_addr;
            bus.mem_data  = bus.st_data;
        end
    end

    assign bus.ld_stall = stall;
    assign bus.sb_empty = (cnt == '0);
    assign bus.sb_count = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            e_valid <= '0;
        end else begin
            if (push) begin
                tail <= tail + P_ONE;
                e_valid[tail] <= 1'b1;
            end
            if (drain) begin
                head <= head + P_ONE;
                e_valid[head] <= 1'b0;
            end
            if (push && !drain)
                cnt <= cnt + C_ONE;
            else if (drain && !push)
                cnt <= cnt - C_ONE;
        end
    end

    // Payload needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            e_func3[tail] <= bus.st_func3;
            e_addr[tail]  <= bus.st_addr;
            e_data[tail]  <= bus.st_data;
        end
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the memory-stage store path and the data memory. Accepts stores from the core in one cycle, queues them in a small FIFO and drains one per cycle into the data memory's write port whenever that port is not needed by a load. Detects byte overlap between a pending load and any queued store and stalls the load until the conflicting stores have drained.

## Interface
Parameters:
- DEPTH, 4, number of queued stores (power of two, ≥2)
- ADDR_W, 8, byte-address width; matches data memory index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- st_valid  in  1  core presents a store this cycle
- st_func3  in  3  store size: 000 SB, 001 SH, 010 SW
- st_addr  in  ADDR_W  store byte address
- st_data  in  32  store data, right-aligned
- st_ready  out  1  buffer accepts a store this cycle
- ld_valid  in  1  core presents a load this cycle
- ld_func3  in  3  load size/sign code
- ld_addr  in  ADDR_W  load byte address
- ld_stall  out  1  load conflicts with a queued store; core must hold
- mem_write  out  1  write strobe to data memory
- mem_func3  out  3  size to data memory
- mem_addr  out  ADDR_W  address to data memory
- mem_data  out  32  data to data memory
- sb_empty  out  1  no stores queued (used by FENCE)
- sb_count  out  $clog2(DEPTH)+1  number of queued entries

## Operation
- Storage: DEPTH entries {func3, addr, data, valid}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- Enqueue: st_valid && st_ready writes entry at tail, tail+1, count+1.
- st_ready = (count < DEPTH). Push into full buffer is not permitted even if a drain occurs same cycle.
- st_func3 not in {000,001,010}: accepted (st_ready semantics unchanged), no entry created, discarded.
- Port free: port_free = !ld_valid || ld_stall.
- Drain: when count>0 && port_free, mem_write=1 and mem_* present head entry; head+1, count-1 on that edge.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Overlap: store span = addr .. addr+size-1, size 1/2/4 for 000/001/010. Load span uses size 1 for 000/100, 2 for 001/101, 4 for all other codes. Arithmetic modulo 2^ADDR_W (span at 0xFF of size 2 covers 0xFF and 0x00).
- ld_stall = ld_valid && any valid entry span intersects load span. Store presented the same cycle (not yet queued) is not checked.
- Ordering: stores drain strictly in FIFO order; no store-to-load forwarding.
- sb_empty = (count == 0); sb_count = count.

## Timing
- Reset (rst low, asynchronous): count 0, head/tail 0, all valid bits 0; mem_write 0, mem_func3 0, mem_addr 0, mem_data 0, ld_stall 0, st_ready 1, sb_empty 1, sb_count 0. Reset mid-operation discards all queued stores; no write issued.
- st_ready, ld_stall, mem_* are combinational from registered state and current inputs; no registered outputs.
- Store latency without bypass: accepted on edge N, earliest memory write on edge N+1.
- Stalled load: ld_stall drops in the cycle after the last overlapping entry drains; the load is held at most count cycles.
- Continuous loads with no overlap block draining indefinitely; stores keep accepting until full, then st_ready=0.

## Configuration
- STORE_BYPASS_EN defined: when count==0, port_free and st_valid with a legal func3, the store drives mem_* directly with mem_write=1 that same cycle and is not enqueued (zero-latency write). Bypass never occurs when count>0 (preserves order).
- Not defined: every legal store is enqueued; minimum one-cycle latency to memory.

## Test plan
- Reset mid-drain: enqueue 3 SW, assert rst low after first drain -> mem_write 0 immediately, sb_count 0, no further writes after release.
- Fill/full: 4 back-to-back SW to 0x00,0x04,0x08,0x0C with ld_valid=1, non-overlapping load at 0x40 -> st_ready 0 after 4th, 5th held; drop ld_valid -> writes in order 0x00..0x0C, one per cycle, sb_empty 1 after 4 cycles.
- Overlap stall: queue SB 0x13 data 0xAB, then LW 0x10 -> ld_stall 1, mem_write 1 addr 0x13 func3 000, next cycle ld_stall 0.
- Wrap-around span: queue SH at 0xFF, LB at 0x00 -> ld_stall 1 until drained; LB at 0x01 -> ld_stall 0.
- Simultaneous push/drain at count 2, ld_valid 0 -> count stays 2, head and tail both advance, including pointer wrap from 3 to 0.
- Illegal func3 011 store -> st_ready 1, sb_count unchanged, no mem_write; with STORE_BYPASS_EN, empty buffer SW 0x20 data 0xDEADBEEF -> mem_write same cycle, sb_count stays 0.
